// File: rtl/stats_scheduler_pkg.sv
// Shared types and constants for the game-result statistics scheduler.
// Default widths live here so the divider and the top agree on the accumulator width.
package stats_scheduler_pkg;

  localparam int SCORE_W_DEF    = 6;
  localparam int DEPTH_LOG2_DEF = 5;
  localparam int SUM_W          = SCORE_W_DEF + DEPTH_LOG2_DEF;

  typedef enum logic [1:0] {SHOW, SCAN, DIV} state_t;

  localparam logic [3:0] LET_AVG  = 4'hA;
  localparam logic [3:0] LET_BEST = 4'hB;
  localparam logic [3:0] LET_CNT  = 4'hC;
  localparam logic [3:0] LET_LAST = 4'hE;

  function automatic logic [3:0] letter_code(input logic [1:0] idx);
    logic [3:0] code;
    case (idx)
      2'd0:    code = LET_AVG;
      2'd1:    code = LET_BEST;
      2'd2:    code = LET_CNT;
      default: code = LET_LAST;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/stats_scheduler_divider.sv
// Restoring divider: one quotient bit per cycle, the dividend shifts out of the quotient register.
// A new start always reloads, so an abandoned division never leaks into the next one.
module seq_divider
  import stats_scheduler_pkg::*;
#(
  parameter int DIVIDEND_W = SUM_W,
  parameter int DIVISOR_W  = DEPTH_LOG2_DEF + 1,
  parameter int QUOT_W     = SCORE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  done
);

  localparam int STEP_W = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] acc;
  logic [DIVISOR_W-1:0]  rem;
  logic [STEP_W-1:0]     step;
  logic                  running;
  logic [DIVISOR_W:0]    shifted;

  assign shifted  = {rem, acc[DIVIDEND_W-1]};
  assign quotient = acc[QUOT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      rem     <= '0;
      step    <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= dividend;
        rem     <= '0;
        step    <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (shifted >= {1'b0, divisor}) begin
          rem <= DIVISOR_W'(shifted - {1'b0, divisor});
          acc <= {acc[DIVIDEND_W-2:0], 1'b1};
        end else begin
          rem <= shifted[DIVISOR_W-1:0];
          acc <= {acc[DIVIDEND_W-2:0], 1'b0};
        end
        step <= step + STEP_W'(1);
        if (step == STEP_W'(DIVIDEND_W - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stats_scheduler.sv
// Owns the result memory port: stores game scores, rescans them after every write,
// and rotates avg/best/count/last onto the stats letter and two-digit display.
module stats_scheduler
  import stats_scheduler_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int SCORE_W    = SCORE_W_DEF,
  parameter int DWELL      = 100_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [SCORE_W-1:0]    wr_score,
  input  logic                  clear_stats,
  input  logic                  next_stat,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_we,
  output logic [SCORE_W-1:0]    mem_wdata,
  input  logic [SCORE_W-1:0]    mem_rdata,
  output logic [3:0]            statsLetter,
  output logic [7:0]            statsDisplay,
  output logic                  busy
);

  localparam int CNT_W   = DEPTH_LOG2 + 1;
  localparam int DWELL_W = $clog2(DWELL + 1);

  state_t                state;
  logic [DEPTH_LOG2-1:0] wr_ptr, base;
  logic [CNT_W-1:0]      count, issue_idx, cap_idx, pub_count;
  logic                  issue_v, cap_v;
  logic [SUM_W-1:0]      sum;
  logic [SCORE_W-1:0]    run_max, run_last, pub_avg, pub_best, pub_last, div_quo;
  logic                  div_start, div_done;
  logic [1:0]            let_idx;
  logic [DWELL_W-1:0]    dwell_cnt;

  assign base = wr_ptr - count[DEPTH_LOG2-1:0];
  assign busy = (state != SHOW);

  seq_divider #(
    .DIVIDEND_W(SUM_W),
    .DIVISOR_W (CNT_W),
    .QUOT_W    (SCORE_W)
  ) u_div (
    .clk     (CLOCK_50),
    .reset   (reset),
    .start   (div_start),
    .dividend(sum),
    .divisor (count),
    .quotient(div_quo),
    .done    (div_done)
  );

  // Reads return one cycle after the address, so captures trail issues by a two-stage valid pipe.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= SHOW;
      wr_ptr    <= '0;
      count     <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      issue_idx <= '0;
      cap_idx   <= '0;
      issue_v   <= 1'b0;
      cap_v     <= 1'b0;
      sum       <= '0;
      run_max   <= '0;
      run_last  <= '0;
      div_start <= 1'b0;
      pub_avg   <= '0;
      pub_best  <= '0;
      pub_last  <= '0;
      pub_count <= '0;
    end else begin
      mem_we    <= 1'b0;
      div_start <= 1'b0;
      if (clear_stats) begin
        state     <= SHOW;
        wr_ptr    <= '0;
        count     <= '0;
        issue_v   <= 1'b0;
        cap_v     <= 1'b0;
        pub_avg   <= '0;
        pub_best  <= '0;
        pub_last  <= '0;
        pub_count <= '0;
      end else if (wr_req) begin
        mem_we    <= 1'b1;
        mem_addr  <= wr_ptr;
        mem_wdata <= wr_score;
        wr_ptr    <= wr_ptr + DEPTH_LOG2'(1);
        if (count != CNT_W'(1 << DEPTH_LOG2))
          count <= count + CNT_W'(1);
        state     <= SCAN;
        issue_idx <= '0;
        cap_idx   <= '0;
        issue_v   <= 1'b0;
        cap_v     <= 1'b0;
        sum       <= '0;
        run_max   <= '0;
      end else begin
        case (state)
          SCAN: begin
            if (count == '0) begin
              pub_avg   <= '0;
              pub_best  <= '0;
              pub_last  <= '0;
              pub_count <= '0;
              state     <= SHOW;
            end else begin
              issue_v <= (issue_idx < count);
              if (issue_idx < count) begin
                mem_addr  <= base + issue_idx[DEPTH_LOG2-1:0];
                issue_idx <= issue_idx + CNT_W'(1);
              end
              cap_v <= issue_v;
              if (cap_v) begin
                sum     <= sum + SUM_W'(mem_rdata);
                cap_idx <= cap_idx + CNT_W'(1);
                if (mem_rdata > run_max)
                  run_max <= mem_rdata;
                if (cap_idx == count - CNT_W'(1)) begin
                  run_last  <= mem_rdata;
                  div_start <= 1'b1;
                  state     <= DIV;
                end
              end
            end
          end
          // A done seen while start is still pending belongs to an abandoned division.
          DIV: begin
            if (div_done && !div_start) begin
              pub_avg   <= div_quo;
              pub_best  <= run_max;
              pub_last  <= run_last;
              pub_count <= count;
              state     <= SHOW;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      let_idx   <= 2'd0;
      dwell_cnt <= '0;
    end else if (next_stat || dwell_cnt == DWELL_W'(DWELL - 1)) begin
      let_idx   <= let_idx + 2'd1;
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      statsLetter  <= LET_AVG;
      statsDisplay <= '0;
    end else begin
      statsLetter <= letter_code(let_idx);
      case (let_idx)
        2'd0:    statsDisplay <= 8'(pub_avg);
        2'd1:    statsDisplay <= 8'(pub_best);
        2'd2:    statsDisplay <= 8'(pub_count);
        default: statsDisplay <= 8'(pub_last);
      endcase
    end
  end

endmodule
